// File: rtl/pwm_tone_meter.sv
// pwm_tone_meter: measures the half-period of a square-wave tone on pwm_in in
// new_clk_in cycles. A tone that toggles every C+1 clocks reads back as C, the
// same convention the tone generator uses for counter_value_button.
//
// Build option: define PWM_TONE_METER_STABLE_EN to require STABLE_N
// consecutive matching measurements (within TOL) before tone_valid rises.
// Without it, the first measurement after arming locks immediately and
// measured_count simply tracks every measurement.
module pwm_tone_meter #(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned TIMEOUT  = 20'hFFFFF,
  parameter int unsigned TOL      = 1,
  parameter int unsigned STABLE_N = 3
) (
  input  logic             new_clk_in,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] measured_count,
  output logic             sample_strobe,
  output logic             tone_valid,
  output logic             silent
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Match counter only has to hold 0..STABLE_N.
  localparam int unsigned MW = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH:0]   TOL_C     = (WIDTH + 1)'(TOL);
  localparam logic [MW-1:0]    STABLE_C  = MW'(STABLE_N);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  logic             s1, s2, s3;
  logic             pwm_edge;
  logic [WIDTH-1:0] hc;
  logic             timeout;

  logic [1:0]       state, state_nxt;
  logic [MW-1:0]    match_cnt, match_nxt, match_inc;
  logic [WIDTH-1:0] meas_nxt;
  logic             strobe_nxt;

  logic [WIDTH:0]   hc_x, meas_x, m_diff;
  logic             m_match;

  // Two-flop synchronizer for the asynchronous tone, plus a history flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that existed before the clock edge, independent of block order.
  always_ff @(posedge new_clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Both polarities of transition count as an edge.
  assign pwm_edge = s2 ^ s3;

  // Silence is declared once the half-period counter saturates.
  assign timeout = (hc == TIMEOUT_C);

  // Half-period counter: restarts on every edge, holds at TIMEOUT.
  always_ff @(posedge new_clk_in or posedge rst) begin
    if (rst) begin
      hc <= '0;
    end else if (pwm_edge) begin
      hc <= '0;
    end else if (!timeout) begin
      hc <= hc + WIDTH'(1);
    end
  end

  // Distance between this measurement and the previous one, one bit wider so
  // the subtraction can never wrap.
  always_comb begin
    hc_x   = {1'b0, hc};
    meas_x = {1'b0, measured_count};
    if (hc_x >= meas_x) begin
      m_diff = hc_x - meas_x;
    end else begin
      m_diff = meas_x - hc_x;
    end
    m_match = (m_diff <= TOL_C);
  end

  // Match count after a measurement: restart on the first sample or on a
  // mismatch, otherwise count up and hold at STABLE_N.
  always_comb begin
    if ((match_cnt == '0) || !m_match) begin
      match_inc = MATCH_ONE;
    end else if (match_cnt >= STABLE_C) begin
      match_inc = STABLE_C;
    end else begin
      match_inc = match_cnt + MATCH_ONE;
    end
  end

  // Next-state and next-output decision for IDLE / ARMED / LOCKED.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    meas_nxt   = measured_count;
    strobe_nxt = 1'b0;

    if (timeout) begin
      // Silence wins; a coincident edge is then treated as a first edge.
      state_nxt = pwm_edge ? ARMED : IDLE;
      match_nxt = '0;
      meas_nxt  = '0;
    end else if (pwm_edge) begin
      case (state)
        IDLE: begin
          // First edge only starts a measurement window.
          state_nxt = ARMED;
          match_nxt = '0;
        end
        ARMED: begin
          meas_nxt   = hc;
          strobe_nxt = 1'b1;
          match_nxt  = match_inc;
`ifdef PWM_TONE_METER_STABLE_EN
          if (match_inc >= STABLE_C) begin
            state_nxt = LOCKED;
          end
`else
          state_nxt = LOCKED;
`endif
        end
        LOCKED: begin
          meas_nxt   = hc;
          strobe_nxt = 1'b1;
          match_nxt  = match_inc;
`ifdef PWM_TONE_METER_STABLE_EN
          if (!m_match) begin
            state_nxt = ARMED;
          end
`endif
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end
  end

  // State and registered outputs; status flags follow the next state so they
  // change together with the strobe that caused the transition.
  always_ff @(posedge new_clk_in or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      match_cnt      <= '0;
      measured_count <= '0;
      sample_strobe  <= 1'b0;
      tone_valid     <= 1'b0;
      silent         <= 1'b1;
    end else begin
      state          <= state_nxt;
      match_cnt      <= match_nxt;
      measured_count <= meas_nxt;
      sample_strobe  <= strobe_nxt;
      tone_valid     <= (state_nxt == LOCKED);
      silent         <= (state_nxt == IDLE);
    end
  end

endmodule
